// File: rtl/mcpu6bit_ctrl.sv
// Run controller and memory arbiter for the 6-bit accumulator CPU.
// Owns the 16x6 memory and shares it between the CPU and the host load/dump port.
module mcpu6bit_ctrl #(
    parameter int unsigned MAX_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic       cmd_ready,
    input  logic       ld_valid,
    input  logic [5:0] ld_data,
    output logic       ld_ready,
    output logic       rd_valid,
    output logic [5:0] rd_data,
    input  logic       rd_ready,
    input  logic       brk_en,
    input  logic [3:0] brk_addr,
    output logic       cpu_rst_n,
    output logic       cpu_ce,
    input  logic       cpu_fetch,
    input  logic [3:0] cpu_addr,
    input  logic [5:0] cpu_dout,
    input  logic       cpu_we_n,
    output logic [5:0] cpu_din,
    output logic       running,
    output logic       halted,
    output logic       brk_hit,
    output logic       timeout
);

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StStep, StHalt, StDump} state_e;

    localparam logic [1:0] CmdLoad = 2'b00;
    localparam logic [1:0] CmdRun  = 2'b01;
    localparam logic [1:0] CmdStep = 2'b10;
    localparam logic [1:0] CmdDump = 2'b11;
    localparam logic [7:0] WdLast  = 8'(MAX_CYCLES - 1);
    localparam bit         WdEn    = (MAX_CYCLES != 0);

    state_e     state_q, state_d;
    logic [3:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic       brk_hit_q, brk_hit_d;
    logic       timeout_q, timeout_d;
    logic       dump_halt_q, dump_halt_d;
    logic       skip_brk_q, skip_brk_d;
    logic [5:0] mem_q [16];

    logic cmd_acc, brk_fire, wd_fire, ld_we;

    assign cmd_ready = (state_q == StIdle) || (state_q == StHalt);
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign ld_ready  = (state_q == StLoad);
    assign rd_valid  = (state_q == StDump);
    assign rd_data   = rd_valid ? mem_q[ptr_q] : '0;
    assign cpu_din   = mem_q[cpu_addr];
    assign running   = (state_q == StRun) || (state_q == StStep);
    assign halted    = (state_q == StHalt);
    assign brk_hit   = brk_hit_q;
    assign timeout   = timeout_q;

    // The CPU sits in reset until it has been run or stepped at least once.
    assign cpu_rst_n = !((state_q == StIdle) || (state_q == StLoad) ||
                         ((state_q == StDump) && !dump_halt_q));

    // Break gates the enable combinationally so the fetch at brk_addr never happens.
    assign brk_fire = (state_q == StRun) && !skip_brk_q && brk_en && cpu_fetch &&
                      (cpu_addr == brk_addr);
    assign cpu_ce   = ((state_q == StRun) && !brk_fire) || (state_q == StStep);
    assign wd_fire  = WdEn && (state_q == StRun) && cpu_ce && (cnt_q == WdLast);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        brk_hit_d   = brk_hit_q;
        timeout_d   = timeout_q;
        dump_halt_d = dump_halt_q;
        skip_brk_d  = skip_brk_q;
        ld_we       = 1'b0;
        case (state_q)
            StIdle, StHalt: begin
                if (cmd_acc) begin
                    unique case (cmd)
                        CmdLoad: begin
                            if (state_q == StIdle) begin
                                state_d = StLoad;
                                ptr_d   = '0;
                            end
                        end
                        CmdRun: begin
                            state_d    = StRun;
                            cnt_d      = '0;
                            brk_hit_d  = 1'b0;
                            timeout_d  = 1'b0;
                            skip_brk_d = (state_q == StHalt);
                        end
                        CmdStep: begin
                            state_d   = StStep;
                            brk_hit_d = 1'b0;
                            timeout_d = 1'b0;
                        end
                        CmdDump: begin
                            state_d     = StDump;
                            ptr_d       = '0;
                            dump_halt_d = (state_q == StHalt);
                        end
                    endcase
                end
            end
            StLoad: begin
                if (ld_valid) begin
                    ld_we = 1'b1;
                    ptr_d = ptr_q + 4'd1;
                    if (ptr_q == 4'hf) state_d = StIdle;
                end
            end
            StRun: begin
                skip_brk_d = 1'b0;
                if (brk_fire) begin
                    state_d   = StHalt;
                    brk_hit_d = 1'b1;
                end else if (wd_fire) begin
                    state_d   = StHalt;
                    timeout_d = 1'b1;
                end
            end
            StStep: state_d = StHalt;
            StDump: begin
                if (rd_ready) begin
                    ptr_d = ptr_q + 4'd1;
                    if (ptr_q == 4'hf) state_d = dump_halt_q ? StHalt : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (cpu_ce) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            cnt_q       <= '0;
            brk_hit_q   <= 1'b0;
            timeout_q   <= 1'b0;
            dump_halt_q <= 1'b0;
            skip_brk_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            brk_hit_q   <= brk_hit_d;
            timeout_q   <= timeout_d;
            dump_halt_q <= dump_halt_d;
            skip_brk_q  <= skip_brk_d;
        end
    end

    // Host loads only while the CPU is held in reset, so the two writers never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem_q[i] <= '0;
        end else if (ld_we) begin
            mem_q[ptr_q] <= ld_data;
        end else if (cpu_ce && !cpu_we_n) begin
            mem_q[cpu_addr] <= cpu_dout;
        end
    end

endmodule

// File: tb/tb_mcpu6bit_ctrl.sv
// Self-checking bench for mcpu6bit_ctrl: load/dump vector tables with a scoreboard queue,
// plus hand-written run, break, step and reset sequences driven by a tiny CPU stub.
module tb_mcpu6bit_ctrl;

    localparam logic [1:0] CmdLoad = 2'b00;
    localparam logic [1:0] CmdRun  = 2'b01;
    localparam logic [1:0] CmdStep = 2'b10;
    localparam logic [1:0] CmdDump = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       cmd_ready;
    logic       ld_valid;
    logic [5:0] ld_data;
    logic       ld_ready;
    logic       rd_valid;
    logic [5:0] rd_data;
    logic       rd_ready;
    logic       brk_en;
    logic [3:0] brk_addr;
    logic       cpu_rst_n;
    logic       cpu_ce;
    logic       cpu_fetch;
    logic [3:0] cpu_addr;
    logic [5:0] cpu_dout;
    logic       cpu_we_n;
    logic [5:0] cpu_din;
    logic       running;
    logic       halted;
    logic       brk_hit;
    logic       timeout;

    mcpu6bit_ctrl #(.MAX_CYCLES(20)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_ready  (rd_ready),
        .brk_en    (brk_en),
        .brk_addr  (brk_addr),
        .cpu_rst_n (cpu_rst_n),
        .cpu_ce    (cpu_ce),
        .cpu_fetch (cpu_fetch),
        .cpu_addr  (cpu_addr),
        .cpu_dout  (cpu_dout),
        .cpu_we_n  (cpu_we_n),
        .cpu_din   (cpu_din),
        .running   (running),
        .halted    (halted),
        .brk_hit   (brk_hit),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] data;
        logic [5:0] exp;
    } vec_t;

    vec_t       tbl [32];
    logic [5:0] exp_q [$];
    logic [3:0] pc;
    int         total = 0;
    int         bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] c);
        cmd       = c;
        cmd_valid = 1'b1;
        step_clk();
        cmd_valid = 1'b0;
    endtask

    task automatic load_words(input int base, input bit gaps, output int cycles);
        send_cmd(CmdLoad);
        cycles = 0;
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                ld_valid = 1'b0;
                #1;
                chk("load ld_ready idle slot", ld_ready, 1);
                step_clk();
                cycles++;
            end
            ld_valid = 1'b1;
            ld_data  = tbl[base+i].data;
            exp_q.push_back(tbl[base+i].exp);
            #1;
            chk("load ld_ready", ld_ready, 1);
            step_clk();
            cycles++;
        end
        ld_valid = 1'b0;
        #1;
        chk("load exit ld_ready", ld_ready, 0);
        chk("load exit cmd_ready", cmd_ready, 1);
    endtask

    task automatic dump_words(input bit throttle, input bit from_halt, output int cycles);
        int n;
        send_cmd(CmdDump);
        cycles = 0;
        n = 0;
        while (n < 16 && cycles < 200) begin
            rd_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            chk("dump rd_valid", rd_valid, 1);
            chk("dump cpu_rst_n", cpu_rst_n, 32'(from_halt));
            if (rd_ready) begin
                chk("dump queue nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("dump word", rd_data, exp_q.pop_front());
                n++;
            end
            step_clk();
            cycles++;
        end
        rd_ready = 1'b0;
        #1;
        chk("dump word count", n, 16);
        chk("dump exit rd_valid", rd_valid, 0);
        chk("dump exit cmd_ready", cmd_ready, 1);
        chk("dump exit halted", halted, 32'(from_halt));
    endtask

    // CPU stub: fetches pc each cycle and advances it on every enabled cycle.
    task automatic run_until_halt(input int budget, input int store_at, output int ces,
                                  output logic last_ce);
        ces     = 0;
        last_ce = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (ces == store_at) begin
                cpu_fetch = 1'b0;
                cpu_addr  = 4'hf;
                cpu_we_n  = 1'b0;
                cpu_dout  = 6'h2a;
            end else begin
                cpu_fetch = 1'b1;
                cpu_addr  = pc;
                cpu_we_n  = 1'b1;
            end
            #1;
            if (halted) break;
            last_ce = cpu_ce;
            if (cpu_ce) ces++;
            step_clk();
            if (last_ce) pc = pc + 4'd1;
        end
        cpu_we_n  = 1'b1;
        cpu_fetch = 1'b0;
        #1;
        chk("run halts within budget", halted, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int   cyc;
        int   ces;
        logic lce;

        for (int i = 0; i < 16; i++) begin
            tbl[i].data      = 6'(i);
            tbl[i].exp       = 6'(i);
            tbl[16+i].data   = 6'((i * 5 + 33) % 64);
            tbl[16+i].exp    = 6'((i * 5 + 33) % 64);
        end

        rst = 1'b1; cmd_valid = 1'b0; cmd = '0; ld_valid = 1'b0; ld_data = '0;
        rd_ready = 1'b0; brk_en = 1'b0; brk_addr = '0; cpu_fetch = 1'b0;
        cpu_addr = '0; cpu_dout = '0; cpu_we_n = 1'b1; pc = '0;
        step_clk();
        step_clk();
        rst = 1'b0;
        #1;
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset ld_ready", ld_ready, 0);
        chk("reset rd_valid", rd_valid, 0);
        chk("reset rd_data", rd_data, 0);
        chk("reset cpu_rst_n", cpu_rst_n, 0);
        chk("reset cpu_ce", cpu_ce, 0);
        chk("reset status", {running, halted, brk_hit, timeout}, 0);
        chk("reset mem", cpu_din, 0);

        // Plain load and dump, both at one word per cycle.
        load_words(0, 1'b0, cyc);
        chk("load cycles", cyc, 16);
        ld_valid = 1'b1; ld_data = 6'h3f;
        step_clk();
        ld_valid = 1'b0;
        dump_words(1'b0, 1'b0, cyc);
        chk("dump cycles", cyc, 16);

        // Stalled streams.
        load_words(16, 1'b1, cyc);
        chk("gapped load cycles", cyc, 32);
        dump_words(1'b1, 1'b0, cyc);

        // Watchdog: store at word 15, then timeout after exactly 20 enabled cycles.
        send_cmd(CmdRun);
        #1;
        chk("run cpu_rst_n", cpu_rst_n, 1);
        chk("run cpu_ce", cpu_ce, 1);
        chk("run cmd_ready", cmd_ready, 0);
        pc = '0;
        run_until_halt(60, 5, ces, lce);
        chk("watchdog ce count", ces, 20);
        chk("watchdog timeout", timeout, 1);
        chk("watchdog brk_hit", brk_hit, 0);
        chk("watchdog running", running, 0);
        cpu_addr = 4'hf;
        #1;
        chk("store visible to cpu", cpu_din, 6'h2a);
        for (int i = 0; i < 16; i++) exp_q.push_back(i == 15 ? 6'h2a : tbl[16+i].exp);
        dump_words(1'b0, 1'b1, cyc);

        send_cmd(CmdLoad);
        #1;
        chk("load in halt ignored ld_ready", ld_ready, 0);
        chk("load in halt stays halted", halted, 1);

        // Breakpoint at 4, then leave it and break again on the next visit.
        brk_en = 1'b1; brk_addr = 4'h4; pc = 4'h1;
        send_cmd(CmdRun);
        run_until_halt(60, -1, ces, lce);
        chk("break ce count", ces, 3);
        chk("break ce low at fetch", lce, 0);
        chk("break pc", pc, 4);
        chk("break brk_hit", brk_hit, 1);
        chk("break timeout", timeout, 0);
        send_cmd(CmdRun);
        run_until_halt(60, -1, ces, lce);
        chk("rebreak ce count", ces, 16);
        chk("rebreak pc", pc, 4);
        chk("rebreak brk_hit", brk_hit, 1);

        // Steps ignore the breakpoint and clear sticky status.
        cpu_fetch = 1'b1; cpu_addr = 4'h4;
        ces = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (cpu_ce) ces++;
            send_cmd(CmdStep);
            #1;
            chk("step cpu_ce", cpu_ce, 1);
            chk("step running", running, 1);
            chk("step status cleared", {brk_hit, timeout}, 0);
            if (cpu_ce) ces++;
            step_clk();
            chk("step back to halt", halted, 1);
            if (cpu_ce) ces++;
        end
        chk("step ce total", ces, 3);
        cpu_fetch = 1'b0;

        // Reset in the middle of a run.
        brk_en = 1'b0;
        send_cmd(CmdRun);
        step_clk();
        cmd = CmdDump; cmd_valid = 1'b1;
        step_clk();
        cmd_valid = 1'b0;
        #1;
        chk("cmd ignored while running", running, 1);
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
        cpu_addr = 4'hf;
        #1;
        chk("rst in run cmd_ready", cmd_ready, 1);
        chk("rst in run cpu_rst_n", cpu_rst_n, 0);
        chk("rst in run cpu_ce", cpu_ce, 0);
        chk("rst in run status", {running, halted, brk_hit, timeout}, 0);
        chk("rst in run mem cleared", cpu_din, 0);

        // Reset in the middle of a dump.
        load_words(0, 1'b0, cyc);
        send_cmd(CmdDump);
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("partial dump word", rd_data, exp_q.pop_front());
            step_clk();
        end
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
        rd_ready = 1'b0;
        exp_q.delete();
        cpu_addr = 4'h1;
        #1;
        chk("rst in dump rd_valid", rd_valid, 0);
        chk("rst in dump rd_data", rd_data, 0);
        chk("rst in dump cmd_ready", cmd_ready, 1);
        chk("rst in dump mem cleared", cpu_din, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
